muldiv_unit: RTL and testbench

Parametrised, multi-cycle RISC-V "M" extension execution unit that sits beside the combinational ALU in the execute stage. It accepts one operation per valid/ready handshake and computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU iteratively, one bit per cycle. It returns the result through a second valid/ready handshake so the pipeline can stall on it. Operation encoding matches RISC-V funct3 so the decoder drives it directly.

---
 rtl/muldiv_unit.sv | 187 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RISC-V M-extension multiply/divide unit, one bit per cycle
// Optional macro MULDIV_FAST_MUL_EN: MUL* ops use a single-cycle multiplier and skip CALC.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      md_op,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] md_out,
    output logic            busy
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2} state_t;
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              neg_q, neg_d;
    logic              neg_rem_q, neg_rem_d;
    logic [XLEN-1:0]   md_out_q, md_out_d;

    logic              accept, is_div, s1, s2;
    logic              div_zero, div_ovf, special, short_path;
    logic [XLEN-1:0]   mag1, mag2, special_res;

    assign accept = in_valid && in_ready;
    assign is_div = md_op[2];
    // s1/s2 are the operand sign bits, forced to 0 where the op treats that operand as unsigned
    assign s1   = in1[XLEN-1] & (is_div ? ~md_op[0] : (md_op[1:0] != 2'b11));
    assign s2   = in2[XLEN-1] & (is_div ? ~md_op[0] : ~md_op[1]);
    assign mag1 = s1 ? -in1 : in1;
    assign mag2 = s2 ? -in2 : in2;

    assign div_zero = is_div && (in2 == '0);
    assign div_ovf  = is_div && !md_op[0] && (in1 == MOST_NEG) && (in2 == '1);
    assign special  = div_zero || div_ovf;

    always_comb begin
        special_res = '0;
        if (div_zero) begin
            special_res = md_op[1] ? in1 : '1;
        end else if (!md_op[1]) begin
            special_res = in1;
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    logic signed [2*XLEN-1:0] fast_a, fast_b, fast_p;
    logic [XLEN-1:0]          fast_res;
    assign fast_a     = {{XLEN{s1}}, in1};
    assign fast_b     = {{XLEN{s2}}, in2};
    assign fast_p     = fast_a * fast_b;
    assign fast_res   = (md_op[1:0] == 2'b00) ? fast_p[XLEN-1:0] : fast_p[2*XLEN-1:XLEN];
    assign short_path = special || !is_div;
`else
    assign short_path = special;
`endif

    // acc holds {partial product, multiplier} or {partial remainder, dividend/quotient}
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] acc_step, prod_fin;
    logic [XLEN-1:0]   quot, rem, res_fin;

    assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign div_shift = acc_q[2*XLEN-1:XLEN-1];
    assign div_diff  = div_shift - {1'b0, opb_q};

    always_comb begin
        if (op_q[2]) begin
            acc_step = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                      : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            acc_step = {mul_sum, acc_q[XLEN-1:1]};
        end
    end

    assign prod_fin = neg_q ? -acc_step : acc_step;
    assign quot     = neg_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
    assign rem      = neg_rem_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];

    always_comb begin
        case (op_q)
            3'b000:                 res_fin = prod_fin[XLEN-1:0];
            3'b001, 3'b010, 3'b011: res_fin = prod_fin[2*XLEN-1:XLEN];
            default:                res_fin = op_q[1] ? rem : quot;
        endcase
    end

    always_comb begin
        op_d      = op_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        md_out_d  = md_out_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d      = md_op;
                    neg_d     = s1 ^ s2;
                    neg_rem_d = s1;
                    cnt_d     = CNT_W'(XLEN-1);
                    if (is_div) begin
                        acc_d = {{XLEN{1'b0}}, mag1};
                        opb_d = mag2;
                    end else begin
                        acc_d = {{XLEN{1'b0}}, mag2};
                        opb_d = mag1;
                    end
                    if (special) begin
                        md_out_d = special_res;
                    end
`ifdef MULDIV_FAST_MUL_EN
                    else if (!is_div) begin
                        md_out_d = fast_res;
                    end
`endif
                end
            end
            S_CALC: begin
                acc_d = acc_step;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    md_out_d = res_fin;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = short_path ? S_DONE : S_CALC;
            S_CALC:  if (cnt_q == '0) state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q      <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            md_out_q  <= '0;
        end else begin
            op_q      <= op_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            md_out_q  <= md_out_d;
        end
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE) && !reset;
        busy      = (state_q != S_IDLE);
        out_valid = (state_q == S_DONE);
    end

    assign md_out = md_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed and random self-checking bench for muldiv_unit
// Honours MULDIV_FAST_MUL_EN for the expected multiply latency.
module tb_muldiv_unit;
    localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
    localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, out_valid, out_ready, busy;
    logic [2:0]  md_op;
    logic [31:0] in1, in2, md_out;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .md_op(md_op), .in1(in1), .in2(in2), .out_valid(out_valid),
        .out_ready(out_ready), .md_out(md_out), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint     sa, sb, zb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        zb = longint'({32'd0, b});
        p  = '0;
        case (op)
            OP_MUL, OP_MULH: p = sa * sb;
            OP_MULHSU:       p = sa * zb;
            OP_MULHU:        p = {32'd0, a} * {32'd0, b};
            OP_DIV: begin
                if (b == 32'd0) p = '1;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = {32'd0, a};
                else p = sa / sb;
            end
            OP_DIVU: begin
                if (b == 32'd0) p = '1;
                else p = {32'd0, a} / {32'd0, b};
            end
            OP_REM: begin
                if (b == 32'd0) p = {32'd0, a};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = '0;
                else p = sa % sb;
            end
            default: begin
                if (b == 32'd0) p = {32'd0, a};
                else p = {32'd0, a} % {32'd0, b};
            end
        endcase
        if (op == OP_MULH || op == OP_MULHSU || op == OP_MULHU) return p[63:32];
        return p[31:0];
    endfunction

    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", 32'(in_ready), 32'd1);
        md_op    = op;
        in1      = a;
        in2      = b;
        in_valid = 1'b1;
        exp_q.push_back(exp_res);
        @(negedge clk);
        in_valid = 1'b0;
        md_op    = 3'($urandom);
        in1      = $urandom;
        in2      = $urandom;
    endtask

    task automatic collect(input string tag, input int exp_lat);
        int          lat;
        logic [31:0] exp_res;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        exp_res = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        check({tag, "_res"}, md_out, exp_res);
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        send(op, a, b, exp_res);
        collect(tag, exp_lat);
        @(negedge clk);
        check({tag, "_idle"}, 32'({in_ready, out_valid}), 32'b10);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        int          rlat;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        md_op = '0; in1 = '0; in2 = '0;
        repeat (2) @(negedge clk);
        check("rst_outputs", 32'({in_ready, out_valid, busy}), 32'b000);
        check("rst_md_out", md_out, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'({in_ready, busy}), 32'b10);

        run_op("mul",      OP_MUL,    32'd26,         32'd13,         32'd338,        MUL_LAT);
        run_op("div_neg",  OP_DIV,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  DIV_LAT);
        run_op("rem_neg",  OP_REM,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  DIV_LAT);
        run_op("divu",     OP_DIVU,   32'd26,         32'd13,         32'd2,          DIV_LAT);
        run_op("remu",     OP_REMU,   32'd26,         32'd13,         32'd0,          DIV_LAT);
        run_op("mulh",     OP_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000,  MUL_LAT);
        run_op("mulhu",    OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  MUL_LAT);
        run_op("mulhsu",   OP_MULHSU, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  MUL_LAT);
        run_op("divu_z",   OP_DIVU,   32'd26,         32'd0,          32'hFFFF_FFFF,  1);
        run_op("remu_z",   OP_REMU,   32'd26,         32'd0,          32'd26,         1);
        run_op("div_ovf",  OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1);
        run_op("rem_ovf",  OP_REM,    32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1);

        out_ready = 1'b0;
        send(OP_DIVU, 32'd1000, 32'd7, 32'd142);
        collect("bp", DIV_LAT);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            md_op    = OP_MUL;
            in1      = $urandom;
            in2      = $urandom;
            @(negedge clk);
            check("bp_hold_flags", 32'({out_valid, in_ready, busy}), 32'b101);
            check("bp_hold_data", md_out, 32'd142);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release", 32'({in_ready, out_valid, busy}), 32'b100);
        @(negedge clk);
        check("bp_no_accept", 32'({in_ready, busy}), 32'b10);

        send(OP_DIV, 32'd100, 32'd7, 32'd14);
        repeat (10) @(negedge clk);
        check("mid_calc_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_rst_flags", 32'({busy, out_valid, in_ready}), 32'b001);
        check("mid_rst_md_out", md_out, 32'd0);
        void'(exp_q.pop_front());
        @(negedge clk);
        run_op("div_after_rst", OP_DIV, 32'd100, 32'd7, 32'd14, DIV_LAT);

        for (int i = 0; i < 8; i++) begin
            rop = 3'($urandom);
            ra  = $urandom;
            rb  = (i == 3) ? 32'd0 : $urandom >> (i * 3);
            if (rop[2] && (rb == 32'd0 || (!rop[0] && ra == 32'h8000_0000 && rb == '1)))
                rlat = 1;
            else
                rlat = rop[2] ? DIV_LAT : MUL_LAT;
            run_op("rand", rop, ra, rb, ref_model(rop, ra, rb), rlat);
        end

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
